// File: rtl/byte_ingress_if.sv
// -----------------------------------------------------------------------------
// byte_ingress_if
//   Groups the byte-stream input and the word-side valid/ready output of
//   byte_ingress into one bundle.
//
//   Data      [7:0]  incoming byte
//   DataValid        Data valid this cycle (no backpressure on the byte side)
//   WordData  [31:0] FIFO head word, first-word-fall-through
//   WordValid        FIFO non-empty
//   WordReady        consumer accepts the head when WordValid && WordReady
//
//   master : the environment, which feeds bytes and consumes words
//   slave  : byte_ingress itself
// -----------------------------------------------------------------------------
interface byte_ingress_if;
   logic [7:0]  Data;
   logic        DataValid;
   logic [31:0] WordData;
   logic        WordValid;
   logic        WordReady;

   modport master (
      output Data, DataValid, WordReady,
      input  WordData, WordValid
   );

   modport slave (
      input  Data, DataValid, WordReady,
      output WordData, WordValid
   );
endinterface

// File: rtl/byte_ingress.sv
// -----------------------------------------------------------------------------
// byte_ingress
//   Receive-side counterpart of the byte egress serializer. Bytes arrive least
//   significant first and are assembled into 32-bit words. Completed words go
//   into a small first-word-fall-through FIFO that is drained through a
//   valid/ready handshake. The byte side cannot be stalled, so two kinds of
//   loss are possible. Both raise sticky flags:
//     - a completed word that arrives while the FIFO is full (Overflow)
//     - a partial word that sits idle for too long (Timeout)
//
// Parameters
//   FIFO_DEPTH  word FIFO entries; power of two, >= 2
//   TIMEOUT     idle cycles mid-word before the partial word is discarded;
//               0 disables the timeout
//
// Ports
//   ClkIngress  in   sole clock, rising edge
//   RstN        in   synchronous reset, active-low
//   bus         ifc  byte input and word output (slave side of byte_ingress_if)
//   FifoLevel   out  current FIFO occupancy
//   Overflow    out  sticky: a completed word was dropped because the FIFO was full
//   Timeout     out  sticky: a partial word was discarded by the idle timeout
//   ClearErr    in   clears Overflow and Timeout; a simultaneous new event wins
// -----------------------------------------------------------------------------
module byte_ingress #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                        ClkIngress,
   input  logic                        RstN,
   byte_ingress_if.slave               bus,
   output logic [$clog2(FIFO_DEPTH):0] FifoLevel,
   output logic                        Overflow,
   output logic                        Timeout,
   input  logic                        ClearErr
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // The counter value seen during the TIMEOUT-th consecutive idle cycle.
   localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;

   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [23:0]       partial_q, partial_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              overflow_q, overflow_d;
   logic              timeout_q, timeout_d;
   logic [31:0]       mem_q [FIFO_DEPTH];

   logic        fifo_full;
   logic        pop;
   logic        push_req;
   logic        push;
   logic        ovf_evt;
   logic        to_evt;
   logic [31:0] word_in;

   // Handshake and loss-event decode.
   always_comb begin
      fifo_full = (level_q == LVL_W'(FIFO_DEPTH));
      pop       = (level_q != '0) && bus.WordReady;
      push_req  = bus.DataValid && (byte_idx_q == 2'd3);
      // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
      push      = push_req && (!fifo_full || pop);
      ovf_evt   = push_req && fifo_full && !pop;
      to_evt    = (TIMEOUT != 0) && !bus.DataValid && (byte_idx_q != 2'd0)
                  && (idle_cnt_q == IDLE_LAST);
      word_in   = {bus.Data, partial_q};
   end

   // Byte assembly and idle tracking.
   always_comb begin
      byte_idx_d = byte_idx_q;
      partial_d  = partial_q;
      idle_cnt_d = idle_cnt_q;
      if (bus.DataValid) begin
         byte_idx_d = byte_idx_q + 2'd1;
         idle_cnt_d = '0;
         case (byte_idx_q)
            2'd0:    partial_d[7:0]   = bus.Data;
            2'd1:    partial_d[15:8]  = bus.Data;
            2'd2:    partial_d[23:16] = bus.Data;
            default: partial_d        = '0;   // word leaves with this byte
         endcase
      end else if (byte_idx_q == 2'd0) begin
         idle_cnt_d = '0;
      end else if (to_evt) begin
         byte_idx_d = 2'd0;
         partial_d  = '0;
         idle_cnt_d = '0;
      end else if (TIMEOUT != 0) begin
         idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
   end

   // FIFO bookkeeping and sticky flags (a new event beats ClearErr).
   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
      overflow_d = ovf_evt | (overflow_q & ~ClearErr);
      timeout_d  = to_evt  | (timeout_q  & ~ClearErr);
   end

   always_ff @(posedge ClkIngress) begin
      if (!RstN) begin
         byte_idx_q <= '0;
         partial_q  <= '0;
         idle_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         byte_idx_q <= byte_idx_d;
         partial_q  <= partial_d;
         idle_cnt_q <= idle_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
      end
   end

   // Storage needs no reset: the level counter decides what is visible.
   always_ff @(posedge ClkIngress) begin
      if (RstN && push) begin
         mem_q[wr_ptr_q] <= word_in;
      end
   end

   // The head is read combinationally so a word is visible the cycle after it
   // completes; it is forced to zero when empty so stale or uninitialised
   // entries never show.
   always_comb begin
      bus.WordValid = (level_q != '0);
      bus.WordData  = bus.WordValid ? mem_q[rd_ptr_q] : 32'h0;
      FifoLevel     = level_q;
      Overflow      = overflow_q;
      Timeout       = timeout_q;
   end

endmodule

// File: tb/tb_byte_ingress.sv
// -----------------------------------------------------------------------------
// tb_byte_ingress
//   Directed bench for byte_ingress (FIFO_DEPTH=4, TIMEOUT=16). Inputs change
//   1 time unit after a rising edge and outputs are sampled there too. The
//   sampled values therefore reflect the state after that edge.
// -----------------------------------------------------------------------------
module tb_byte_ingress;
   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 16;

   logic       ClkIngress = 1'b0;
   logic       RstN       = 1'b0;
   logic       ClearErr   = 1'b0;
   logic [2:0] FifoLevel;
   logic       Overflow;
   logic       Timeout;

   byte_ingress_if bus ();

   byte_ingress #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .ClkIngress (ClkIngress),
      .RstN       (RstN),
      .bus        (bus),
      .FifoLevel  (FifoLevel),
      .Overflow   (Overflow),
      .Timeout    (Timeout),
      .ClearErr   (ClearErr)
   );

   always #5 ClkIngress = ~ClkIngress;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_ovf  [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
   logic [31:0] exp_sim  [4] = '{32'h28272625, 32'h2C2B2A29, 32'h302F2E2D, 32'h34333231};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %s = %h", tag, got);
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ClkIngress);
      #1;
   endtask

   task automatic put(input logic [7:0] b);
      bus.Data      = b;
      bus.DataValid = 1'b1;
      tick();
   endtask

   task automatic idle(input int n);
      bus.DataValid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic clear_err();
      bus.DataValid = 1'b0;
      ClearErr      = 1'b1;
      tick();
      ClearErr      = 1'b0;
   endtask

   initial begin
      bus.Data      = 8'hFF;
      bus.DataValid = 1'b1;
      bus.WordReady = 1'b0;

      // 1: reset held with bytes arriving
      RstN = 1'b0;
      repeat (3) tick();
      check_eq("rst_word_data",  bus.WordData, 32'h0);
      check_eq("rst_word_valid", 32'(bus.WordValid), 32'h0);
      check_eq("rst_level",      32'(FifoLevel), 32'h0);
      check_eq("rst_overflow",   32'(Overflow), 32'h0);
      check_eq("rst_timeout",    32'(Timeout), 32'h0);
      bus.DataValid = 1'b0;
      RstN = 1'b1;
      tick();

      // 2: single word, consumer always ready
      bus.WordReady = 1'b1;
      put(8'h11); put(8'h22); put(8'h33);
      check_eq("t2_valid_before", 32'(bus.WordValid), 32'h0);
      put(8'h44);
      check_eq("t2_word",   bus.WordData, 32'h44332211);
      check_eq("t2_valid",  32'(bus.WordValid), 32'h1);
      check_eq("t2_level1", 32'(FifoLevel), 32'h1);
      idle(1);
      check_eq("t2_valid_after", 32'(bus.WordValid), 32'h0);
      check_eq("t2_level0",      32'(FifoLevel), 32'h0);

      // 3: five words into a four-deep FIFO
      bus.WordReady = 1'b0;
      for (int i = 1; i <= 20; i++) put(8'(i));
      bus.DataValid = 1'b0;
      check_eq("t3_level",    32'(FifoLevel), 32'h4);
      check_eq("t3_overflow", 32'(Overflow), 32'h1);
      check_eq("t3_timeout",  32'(Timeout), 32'h0);
      bus.WordReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("t3_pop%0d", k), bus.WordData, exp_ovf[k]);
         tick();
      end
      bus.WordReady = 1'b0;
      check_eq("t3_level_drained", 32'(FifoLevel), 32'h0);
      check_eq("t3_ovf_sticky",    32'(Overflow), 32'h1);
      clear_err();
      check_eq("t3_ovf_cleared",   32'(Overflow), 32'h0);

      // 4: idle timeout after exactly TIMEOUT idle cycles
      put(8'hAA); put(8'hBB);
      idle(15);
      check_eq("t4_no_to_15", 32'(Timeout), 32'h0);
      idle(1);
      check_eq("t4_to_16",    32'(Timeout), 32'h1);
      bus.WordReady = 1'b1;
      put(8'h01); put(8'h02); put(8'h03); put(8'h04);
      check_eq("t4_word", bus.WordData, 32'h04030201);
      idle(1);
      bus.WordReady = 1'b0;
      clear_err();
      check_eq("t4_to_cleared", 32'(Timeout), 32'h0);

      // 5: one idle cycle short of the timeout
      bus.WordReady = 1'b1;
      put(8'hAA); put(8'hBB);
      idle(15);
      put(8'hCC); put(8'hDD);
      check_eq("t5_word",  bus.WordData, 32'hDDCCBBAA);
      check_eq("t5_no_to", 32'(Timeout), 32'h0);
      idle(1);
      bus.WordReady = 1'b0;

      // 6: push and pop together while full, then overflow against ClearErr
      for (int i = 8'h21; i <= 8'h30; i++) put(8'(i));
      put(8'h31); put(8'h32); put(8'h33);
      check_eq("t6_level_full", 32'(FifoLevel), 32'h4);
      bus.WordReady = 1'b1;
      put(8'h34);
      bus.WordReady = 1'b0;
      check_eq("t6_no_ovf",  32'(Overflow), 32'h0);
      check_eq("t6_level",   32'(FifoLevel), 32'h4);
      check_eq("t6_head",    bus.WordData, 32'h28272625);
      put(8'h41); put(8'h42); put(8'h43);
      ClearErr = 1'b1;
      put(8'h44);
      ClearErr = 1'b0;
      bus.DataValid = 1'b0;
      check_eq("t6_set_wins", 32'(Overflow), 32'h1);
      check_eq("t6_level2",   32'(FifoLevel), 32'h4);
      bus.WordReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("t6_pop%0d", k), bus.WordData, exp_sim[k]);
         tick();
      end
      bus.WordReady = 1'b0;
      check_eq("t6_empty", 32'(bus.WordValid), 32'h0);
      clear_err();
      check_eq("t6_ovf_cleared", 32'(Overflow), 32'h0);

      // Reset mid-word with a non-empty FIFO discards everything
      put(8'hA1); put(8'hA2); put(8'hA3); put(8'hA4);
      put(8'h55); put(8'h66);
      bus.DataValid = 1'b0;
      check_eq("rst2_level_before", 32'(FifoLevel), 32'h1);
      RstN = 1'b0;
      tick();
      RstN = 1'b1;
      check_eq("rst2_level", 32'(FifoLevel), 32'h0);
      check_eq("rst2_valid", 32'(bus.WordValid), 32'h0);
      put(8'h01); put(8'h02); put(8'h03); put(8'h04);
      check_eq("rst2_word",  bus.WordData, 32'h04030201);
      check_eq("rst2_level1", 32'(FifoLevel), 32'h1);
      bus.DataValid = 1'b0;
      bus.WordReady = 1'b1;
      tick();
      bus.WordReady = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
